llr_frame_loader: RTL and testbench
===================================

# llr_frame_loader

Input stage of the min-sum decoder datapath. Accepts channel LLRs as a beat stream of four WIDTH-bit lanes, saturates each to a symmetric range, and assembles N_V LLRs into one frame-wide vector. It presents that vector with `data_ready` to the decoder core and its output layer, which consume `all_llrs`. The block holds two frames: one filling and one presented. This lets the next codeword stream in while the decoder iterates.

## Interface
- WIDTH, 8, LLR width in bits (signed two's complement)
- N_V, 44, variable nodes (LLRs) per frame
- LLR_MAX, 2**(WIDTH-1)-1, saturation magnitude, 1 ≤ LLR_MAX ≤ 2**(WIDTH-1)-1
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (assert = 0)
- in_valid  in  1  upstream beat valid
- in_ready  out  1  loader can accept a beat
- llr_in  in  4*WIDTH+1  lanes [WIDTH*k +: WIDTH], k=0..3; bit 4*WIDTH = sof (start of frame)
- all_llrs  out  WIDTH*N_V  presented frame; LLR j at [WIDTH*j +: WIDTH]
- data_ready  out  1  all_llrs holds a complete frame
- frame_ack  in  1  downstream has taken the presented frame
- err_sof  out  1  one-cycle pulse on framing error

## Operation
- Beat accepted when in_valid & in_ready. BEATS = ceil(N_V/4). Beat b, lane k carries LLR 4b+k. Lanes with index ≥ N_V on the final beat are ignored.
- Saturation per lane: x > LLR_MAX → LLR_MAX; x < −LLR_MAX → −LLR_MAX; otherwise x. The value −2**(WIDTH-1) never reaches the output.
- Fill FSM states:
  - IDLE: waits for an accepted beat with sof=1.
    - sof=1: write beat 0, set beat_cnt=1, go to FILL.
    - sof=0: drop the beat, pulse err_sof.
  - FILL: accept beats at cnt=beat_cnt.
    - sof=1 mid-frame: discard the partial frame, pulse err_sof, treat the beat as beat 0 of a new frame (beat_cnt=1).
    - Last beat (beat_cnt=BEATS−1) accepted: go to FULL. When BEATS=1, IDLE goes directly to FULL.
  - FULL: fill buffer complete and waiting for the output buffer. When the output buffer is empty or being released this cycle, copy fill → output and go to IDLE.
- Output buffer: data_ready=1 while occupied. Released on data_ready & frame_ack. all_llrs is stable while data_ready=1. frame_ack while data_ready=0 is ignored.
- in_ready = (state != FULL). Upstream sees back-pressure only when both buffers hold frames.
- beat_cnt width is clog2(BEATS) bits, minimum 1. It never wraps past BEATS−1.

## Timing
- Reset values:
  - in_ready=0 while rst=0, 1 from the first edge after release.
  - data_ready=0, err_sof=0, all_llrs=0.
  - FSM=IDLE, beat_cnt=0.
- Latency: when the output buffer is empty, data_ready rises one cycle after the edge that accepted the last beat (fill→output copy in FULL).
- Release and refill in the same cycle: if data_ready & frame_ack & state==FULL, the new frame loads that edge and data_ready stays 1 with no gap.
- Throughput: one beat per cycle sustained. In FULL with output empty, in_ready is low for exactly one cycle per frame.
- Reset mid-frame or with data_ready high: all frames are discarded and every output returns to its reset value immediately (asynchronous).
- err_sof is asserted in the cycle after the offending beat edge, for one cycle.

## Structure
- Shared package `decoder_pkg`: LLR_W default, N_V/N_C/E defaults, BEATS function (ceil div 4), and a `sat_llr` function used by this block and later the check-node layer.
- One sub-module, `llr_sat`: a single-lane combinational saturator, instanced four times.
- Fill and output buffers are flat registers. No memory inference is needed at N_V=44.

## Test plan
- Single frame: WIDTH=8, N_V=44, 11 back-to-back beats with sof on beat 0 and LLR j = j−20 → data_ready rises 1 cycle after beat 10; all_llrs[8j+:8] = j−20; in_ready low 1 cycle.
- Saturation at LLR_MAX=100: lanes 127, −128, −100, 101 → 100, −100, −100, 100.
- Back-pressure: frame_ack held 0, send 2 frames → in_ready stays low after the second frame's last beat; assert frame_ack → frame 2 is presented on the next edge with data_ready continuously 1, and in_ready returns to 1.
- Framing errors: beat without sof in IDLE → dropped, err_sof 1 cycle. sof on beat 5 of a frame → err_sof pulses and the frame restarts; the resulting frame contains only post-restart data.
- Reset mid-frame: drop rst at beat 6 asynchronously → data_ready=0, all_llrs=0 before the next edge; a fresh full frame afterwards decodes correctly.
- Non-multiple N_V=42: 11 beats → lanes 2,3 of beat 10 are ignored and all_llrs width is 336.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the min-sum decoder datapath: default sizes,
// beat arithmetic, fill-FSM states and the symmetric LLR saturation.
package decoder_pkg;

    localparam int LLR_W   = 8;
    localparam int N_V_DEF = 44;
    localparam int N_C_DEF = 22;
    localparam int E_DEF   = 132;

    typedef enum logic [1:0] {
        FILL_IDLE   = 2'd0,
        FILL_ACTIVE = 2'd1,
        FILL_FULL   = 2'd2
    } fill_state_e;

    function automatic int beats(input int n);
        return (n + 3) / 4;
    endfunction

    // Symmetric clamp; the most negative code never survives.
    function automatic logic signed [31:0] sat_llr(input logic signed [31:0] x,
                                                   input logic signed [31:0] lim);
        if (x > lim)
            return lim;
        else if (x < -lim)
            return -lim;
        return x;
    endfunction

endpackage

// File: rtl/llr_sat.sv
// Single-lane combinational LLR saturator.
module llr_sat
    import decoder_pkg::*;
#(
    parameter int WIDTH   = LLR_W,
    parameter int LLR_MAX = 2**(WIDTH-1) - 1
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] y_o
);

    logic signed [31:0] x_ext;

    assign x_ext = 32'($signed(x_i));
    assign y_o   = WIDTH'(sat_llr(x_ext, 32'(LLR_MAX)));

endmodule

// File: rtl/llr_frame_loader.sv
// Double-buffered LLR frame loader: saturates a 4-lane beat stream into a
// fill buffer and hands completed frames to a presented output buffer.
module llr_frame_loader
    import decoder_pkg::*;
#(
    parameter int WIDTH   = LLR_W,
    parameter int N_V     = N_V_DEF,
    parameter int LLR_MAX = 2**(WIDTH-1) - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*WIDTH:0]       llr_in,
    output logic [WIDTH*N_V-1:0]   all_llrs,
    output logic                   data_ready,
    input  logic                   frame_ack,
    output logic                   err_sof
);

    localparam int BEATS = beats(N_V);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    fill_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH*N_V-1:0]   fill_q, fill_d;
    logic [WIDTH*N_V-1:0]   out_q, out_d;
    logic                   dr_q, dr_d;
    logic                   err_q, err_d;
    logic                   live_q;

    logic [WIDTH-1:0]       sat_lane [4];
    logic                   sof;
    logic                   accept;
    logic                   rel;
    logic                   wr_en;
    logic [CW-1:0]          wr_idx;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        llr_sat #(
            .WIDTH   (WIDTH),
            .LLR_MAX (LLR_MAX)
        ) u_sat (
            .x_i (llr_in[WIDTH*k +: WIDTH]),
            .y_o (sat_lane[k])
        );
    end

    assign sof        = llr_in[4*WIDTH];
    assign in_ready   = live_q && (state_q != FILL_FULL);
    assign accept     = in_valid && in_ready;
    assign rel        = dr_q && frame_ack;
    assign all_llrs   = out_q;
    assign data_ready = dr_q;
    assign err_sof    = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        out_d   = out_q;
        dr_d    = dr_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;

        if (rel)
            dr_d = 1'b0;

        case (state_q)
            FILL_IDLE: begin
                if (accept) begin
                    if (sof) begin
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        if (BEATS == 1) begin
                            state_d = FILL_FULL;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = FILL_ACTIVE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL_ACTIVE: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (sof) begin
                        // Restart: earlier beats get overwritten by the new frame.
                        err_d  = 1'b1;
                        wr_idx = '0;
                        cnt_d  = CW'(1);
                    end else if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = FILL_FULL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FILL_FULL: begin
                if (!dr_q || rel) begin
                    out_d   = fill_q;
                    dr_d    = 1'b1;
                    state_d = FILL_IDLE;
                end
            end
            default: state_d = FILL_IDLE;
        endcase

        // Lanes past N_V on the final beat have no slot and are dropped here.
        for (int j = 0; j < N_V; j++) begin
            if (wr_en && (wr_idx == CW'(j / 4)))
                fill_d[j*WIDTH +: WIDTH] = sat_lane[j % 4];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL_IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            out_q   <= '0;
            dr_q    <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            dr_q    <= dr_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_llr_frame_loader.sv
// Directed bench for llr_frame_loader: default, saturating (LLR_MAX=100)
// and N_V=42 instances driven in lockstep from one beat stream.
module tb_llr_frame_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         frame_ack = 1'b0;
    logic [32:0]  llr_in = '0;

    logic         rdy, dr, err;
    logic [351:0] all_a;
    logic         rdy_s, dr_s, err_s;
    logic [351:0] all_s;
    logic         rdy_n, dr_n, err_n;
    logic [335:0] all_n;

    int total = 0;
    int bad   = 0;
    int cur [44];

    llr_frame_loader #(.WIDTH(8), .N_V(44), .LLR_MAX(127)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy), .llr_in(llr_in),
        .all_llrs(all_a), .data_ready(dr), .frame_ack(frame_ack), .err_sof(err));

    llr_frame_loader #(.WIDTH(8), .N_V(44), .LLR_MAX(100)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .llr_in(llr_in),
        .all_llrs(all_s), .data_ready(dr_s), .frame_ack(frame_ack), .err_sof(err_s));

    llr_frame_loader #(.WIDTH(8), .N_V(42), .LLR_MAX(127)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_n), .llr_in(llr_in),
        .all_llrs(all_n), .data_ready(dr_n), .frame_ack(frame_ack), .err_sof(err_n));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int llr_a(input int j);
        return int'($signed(all_a[8*j +: 8]));
    endfunction

    function automatic int llr_s(input int j);
        return int'($signed(all_s[8*j +: 8]));
    endfunction

    function automatic int llr_n(input int j);
        return int'($signed(all_n[8*j +: 8]));
    endfunction

    task automatic send_beat(input logic sof, input int b);
        int waitc;
        logic [7:0] v [4];
        waitc = 0;
        while (!rdy && waitc < 40) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!rdy)
            check("in_ready_wait", int'(rdy), 1);
        for (int k = 0; k < 4; k++)
            v[k] = (4*b + k < 44) ? 8'(cur[4*b + k]) : 8'd0;
        in_valid = 1'b1;
        llr_in   = {sof, v[3], v[2], v[1], v[0]};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int b = 0; b < 11; b++)
            send_beat(b == 0, b);
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", int'(rdy), 0);
        check("rst_data_ready", int'(dr), 0);
        check("rst_err_sof", int'(err), 0);
        check("rst_all_zero", (all_a == '0) ? 1 : 0, 1);
        @(negedge clk) rst = 1'b1;
        check("rel_in_ready_pre_edge", int'(rdy), 0);
        @(posedge clk); #1;
        check("rel_in_ready", int'(rdy), 1);

        // Frame A: LLR j = j-20, single frame latency
        for (int j = 0; j < 44; j++) cur[j] = j - 20;
        send_frame();
        check("a_in_ready_low", int'(rdy), 0);
        check("a_dr_not_yet", int'(dr), 0);
        @(posedge clk); #1;
        check("a_dr", int'(dr), 1);
        check("a_in_ready_back", int'(rdy), 1);
        check("a_llr0", llr_a(0), -20);
        check("a_llr20", llr_a(20), 0);
        check("a_llr43", llr_a(43), 23);
        check("a_s_llr43", llr_s(43), 23);
        check("a_n_dr", int'(dr_n), 1);
        check("a_n_llr41", llr_n(41), 21);
        ack_frame();
        check("a_released", int'(dr), 0);

        // Frame B (saturation lanes) presented, frame C back-pressured
        for (int j = 0; j < 44; j++) cur[j] = j - 20;
        cur[0] = 127; cur[1] = -128; cur[2] = -100; cur[3] = 101;
        send_frame();
        @(posedge clk); #1;
        check("b_dr", int'(dr), 1);
        for (int j = 0; j < 44; j++) cur[j] = 10 - j;
        send_frame();
        check("c_in_ready_low", int'(rdy), 0);
        repeat (3) begin @(posedge clk); #1; end
        check("c_in_ready_held", int'(rdy), 0);
        check("b_dr_held", int'(dr), 1);
        check("b_sat0", llr_a(0), 127);
        check("b_sat1", llr_a(1), -127);
        check("b_sat2", llr_a(2), -100);
        check("b_sat3", llr_a(3), 101);
        check("b_s_sat0", llr_s(0), 100);
        check("b_s_sat1", llr_s(1), -100);
        check("b_s_sat2", llr_s(2), -100);
        check("b_s_sat3", llr_s(3), 100);
        check("b_n_llr41", llr_n(41), 21);
        ack_frame();
        check("c_dr_no_gap", int'(dr), 1);
        check("c_in_ready_back", int'(rdy), 1);
        check("c_llr0", llr_a(0), 10);
        check("c_llr43", llr_a(43), -33);
        check("c_s_llr43", llr_s(43), -33);
        ack_frame();
        check("c_released", int'(dr), 0);

        // Framing errors
        for (int j = 0; j < 44; j++) cur[j] = j + 50;
        send_beat(1'b0, 0);
        check("idle_nosof_err", int'(err), 1);
        @(posedge clk); #1;
        check("idle_nosof_err_clear", int'(err), 0);
        check("idle_nosof_no_frame", int'(dr), 0);
        for (int b = 0; b < 5; b++) send_beat(b == 0, b);
        check("partial_no_err", int'(err), 0);
        for (int j = 0; j < 44; j++) cur[j] = j - 10;
        send_beat(1'b1, 0);
        check("restart_err", int'(err), 1);
        for (int b = 1; b < 11; b++) begin
            send_beat(1'b0, b);
            if (b == 1) check("restart_err_clear", int'(err), 0);
        end
        @(posedge clk); #1;
        check("d_dr", int'(dr), 1);
        check("d_llr0", llr_a(0), -10);
        check("d_llr4", llr_a(4), -6);
        check("d_llr19", llr_a(19), 9);
        check("d_llr43", llr_a(43), 33);

        // Asynchronous reset mid-frame with a frame presented
        for (int j = 0; j < 44; j++) cur[j] = j;
        for (int b = 0; b < 6; b++) send_beat(b == 0, b);
        #2 rst = 1'b0;
        #1;
        check("arst_dr", int'(dr), 0);
        check("arst_all_zero", (all_a == '0) ? 1 : 0, 1);
        check("arst_in_ready", int'(rdy), 0);
        check("arst_s_dr", int'(dr_s), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("arst_rel_in_ready", int'(rdy), 1);
        check("arst_rel_dr", int'(dr), 0);

        // Fresh frame after reset
        for (int j = 0; j < 44; j++) cur[j] = 20 - j;
        send_frame();
        @(posedge clk); #1;
        check("f_dr", int'(dr), 1);
        check("f_llr0", llr_a(0), 20);
        check("f_llr43", llr_a(43), -23);
        check("f_n_llr0", llr_n(0), 20);
        check("f_n_llr41", llr_n(41), -21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
